// File: rtl/rv32_core_sequencer_pkg.sv
// Shared definitions for the RV32IM multi-cycle sequencer:
// state encodings, trap causes and reset/trap vectors.
package rv32_core_sequencer_pkg;

  localparam int XLEN            = 32;
  localparam int SEQ_STATE_WIDTH = 3;

  typedef logic [XLEN-1:0]            word_t;
  typedef logic [SEQ_STATE_WIDTH-1:0] seq_state_t;

  localparam seq_state_t SEQ_STATE_FETCH  = 3'd0;
  localparam seq_state_t SEQ_STATE_DECODE = 3'd1;
  localparam seq_state_t SEQ_STATE_EXEC   = 3'd2;
  localparam seq_state_t SEQ_STATE_MEM    = 3'd3;
  localparam seq_state_t SEQ_STATE_WB     = 3'd4;
  localparam seq_state_t SEQ_STATE_TRAP   = 3'd5;
  localparam seq_state_t SEQ_STATE_HALT   = 3'd6;

  localparam logic [1:0] TRAP_CAUSE_MISALIGNED = 2'd0;
  localparam logic [1:0] TRAP_CAUSE_ILLEGAL    = 2'd2;

  localparam word_t DEF_RESET_PC = 32'h0000_0000;
  localparam word_t DEF_TRAP_PC  = 32'h0000_0100;
  localparam word_t DEF_NOP_INSN = 32'h0000_0013;

  function automatic logic misaligned(word_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv32_core_sequencer_if.sv
// Instruction-fetch port between the sequencer (master)
// and instruction memory (slave).
interface rv32_core_sequencer_if;
  import rv32_core_sequencer_pkg::*;

  logic  req;
  word_t addr;
  logic  rvalid;
  word_t rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/rv32_perf_counters.sv
// 64-bit cycle and retired-instruction counters.
// Built only when API_SEQ_PERF_CNT_EN is defined.
`ifdef API_SEQ_PERF_CNT_EN
module rv32_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instret_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
);

  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (instret_i) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule
`endif

// File: rtl/rv32_core_sequencer.sv
// Multi-cycle control FSM: owns PC and IR, sequences fetch/exec/mem/wb.
// Optional perf counters via API_SEQ_PERF_CNT_EN.
module rv32_core_sequencer
  import rv32_core_sequencer_pkg::*;
#(
  parameter word_t RESET_PC = DEF_RESET_PC,
  parameter word_t TRAP_PC  = DEF_TRAP_PC,
  parameter word_t NOP_INSN = DEF_NOP_INSN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32_core_sequencer_if.master imem,
  output word_t                 ir_o,
  output word_t                 pc_o,
  input  logic                  dec_reg_w_i,
  input  logic                  dec_mem_w_i,
  input  logic                  dec_is_load_i,
  input  logic                  dec_is_branch_i,
  input  logic                  dec_illegal_i,
  output logic                  ex_start_o,
  input  logic                  ex_done_i,
  output logic                  lsu_req_o,
  input  logic                  lsu_done_i,
  input  logic                  br_taken_i,
  input  word_t                 br_target_i,
  output logic                  rf_we_o,
  output logic                  instret_o,
  input  logic                  halt_i,
  output logic                  halted_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
  output word_t                 trap_epc_o,
  output seq_state_t            state_o
`ifdef API_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]           cycle_cnt_o,
  output logic [63:0]           instret_cnt_o
`endif
);

  seq_state_t state_q, state_d;
  word_t      pc_q, pc_d;
  word_t      ir_q, ir_d;
  word_t      epc_q, epc_d;
  logic [1:0] cause_q, cause_d;
  logic       redirect, bad_tgt, in_wb;

  assign redirect = dec_is_branch_i & br_taken_i;
  assign bad_tgt  = redirect & misaligned(br_target_i);
  assign in_wb    = state_q == SEQ_STATE_WB;

  // Cause and EPC are captured on entry so they are valid with trap_o.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      SEQ_STATE_FETCH: begin
        if (imem.rvalid) begin
          ir_d    = imem.rdata;
          state_d = SEQ_STATE_DECODE;
        end
      end
      SEQ_STATE_DECODE: begin
        if (dec_illegal_i) begin
          state_d = SEQ_STATE_TRAP;
          cause_d = TRAP_CAUSE_ILLEGAL;
          epc_d   = pc_q;
        end else begin
          state_d = SEQ_STATE_EXEC;
        end
      end
      SEQ_STATE_EXEC: begin
        if (ex_done_i)
          state_d = (dec_mem_w_i | dec_is_load_i) ?
                    SEQ_STATE_MEM : SEQ_STATE_WB;
      end
      SEQ_STATE_MEM: begin
        if (lsu_done_i) state_d = SEQ_STATE_WB;
      end
      SEQ_STATE_WB: begin
        if (bad_tgt) begin
          state_d = SEQ_STATE_TRAP;
          cause_d = TRAP_CAUSE_MISALIGNED;
          epc_d   = pc_q;
        end else begin
          pc_d    = redirect ? br_target_i : pc_q + 32'd4;
          state_d = halt_i ? SEQ_STATE_HALT : SEQ_STATE_FETCH;
        end
      end
      SEQ_STATE_TRAP: begin
        pc_d    = TRAP_PC;
        state_d = SEQ_STATE_FETCH;
      end
      SEQ_STATE_HALT: begin
        if (!halt_i) state_d = SEQ_STATE_FETCH;
      end
      default: state_d = SEQ_STATE_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_STATE_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      epc_q   <= '0;
      cause_q <= TRAP_CAUSE_MISALIGNED;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Fetch request is gated by rst_n so it drops the instant reset asserts.
  assign imem.req     = rst_n & (state_q == SEQ_STATE_FETCH);
  assign imem.addr    = pc_q;
  assign ir_o         = ir_q;
  assign pc_o         = pc_q;
  assign ex_start_o   = (state_q == SEQ_STATE_DECODE) & ~dec_illegal_i;
  assign lsu_req_o    = state_q == SEQ_STATE_MEM;
  assign instret_o    = in_wb & ~bad_tgt;
  assign rf_we_o      = instret_o & dec_reg_w_i & ~dec_mem_w_i;
  assign halted_o     = state_q == SEQ_STATE_HALT;
  assign trap_o       = state_q == SEQ_STATE_TRAP;
  assign trap_cause_o = cause_q;
  assign trap_epc_o   = epc_q;
  assign state_o      = state_q;

`ifdef API_SEQ_PERF_CNT_EN
  rv32_perf_counters u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .instret_i     (instret_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );
`endif

endmodule
